digest_scroller: RTL

DIGEST_SCROLLER -- requirements
Module: digest_scroller

---
 rtl/scroller_pkg.sv | 26 ++
 rtl/btn_debounce.sv | 52 +++++
 rtl/digest_scroller.sv | 129 ++++++++++++
 3 files changed

// File: rtl/scroller_pkg.sv
// Shared types and constants for the digest scroller: FSM states, word geometry
// and the modulo-32 index step helper.
package scroller_pkg;

    localparam int WORDS  = 32;
    localparam int WORD_W = 16;
    localparam int IDX_W  = $clog2(WORDS);

    localparam logic [IDX_W-1:0] IDX_LAST = 5'd31;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        MANUAL = 2'd1,
        AUTO   = 2'd2
    } scroll_state_t;

    // One step up or down with natural 5-bit wrap-around.
    function automatic logic [IDX_W-1:0] idx_step(input logic [IDX_W-1:0] idx, input logic up);
        if (up) begin
            return idx + 5'd1;
        end else begin
            return idx - 5'd1;
        end
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, tick-based stability counter and
// single-cycle rising-edge pulse on the accepted level.
module btn_debounce #(
    parameter int DEBOUNCE_TICKS = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic btn,
    output logic rise
);

    localparam int CNT_W = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_TICKS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync1_r;
    logic             sync2_r;
    logic             stable_r;
    logic             rise_r;
    logic [CNT_W-1:0] cnt_r;

    // Synchronize, then accept a new level only after it has differed from the
    // accepted one on DEBOUNCE_TICKS consecutive ticks.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r  <= 1'b0;
            sync2_r  <= 1'b0;
            stable_r <= 1'b0;
            rise_r   <= 1'b0;
            cnt_r    <= '0;
        end else begin
            sync1_r <= btn;
            sync2_r <= sync1_r;
            rise_r  <= 1'b0;
            if (tick) begin
                if (sync2_r == stable_r) begin
                    cnt_r <= '0;
                end else if (cnt_r == CNT_LAST) begin
                    stable_r <= sync2_r;
                    rise_r   <= sync2_r;
                    cnt_r    <= '0;
                end else begin
                    cnt_r <= cnt_r + CNT_ONE;
                end
            end
        end
    end

    assign rise = rise_r;

endmodule

// File: rtl/digest_scroller.sv
// Shows a captured SHA-512 digest one 16-bit word at a time, either auto-scrolling
// on a dwell timer or stepped manually by two debounced buttons.
module digest_scroller
    import scroller_pkg::*;
#(
    parameter int DWELL_TICKS    = 1250,
    parameter int DEBOUNCE_TICKS = 20
) (
    input  logic                    sysclk_125mhz,
    input  logic                    rst,
    input  logic                    tick,
    input  logic                    digest_valid,
    input  logic [WORDS*WORD_W-1:0] digest,
    input  logic                    btn_next,
    input  logic                    btn_prev,
    input  logic                    mode_auto,
    output logic [WORD_W-1:0]       word_out,
    output logic [IDX_W-1:0]        index_out,
    output logic                    loaded,
    output logic                    wrap_pulse
);

    localparam int DW_W = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;
    localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL_TICKS - 1);
    localparam logic [DW_W-1:0] DWELL_ONE  = DW_W'(1);

    scroll_state_t             state_r;
    logic [WORDS*WORD_W-1:0]   captured_r;
    logic [IDX_W-1:0]          index_r;
    logic [DW_W-1:0]           dwell_r;
    logic                      loaded_r;
    logic                      wrap_r;
    logic                      next_rise_s;
    logic                      prev_rise_s;
    logic [WORD_W-1:0]         word_s;

    btn_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_deb_next (
        .clk  (sysclk_125mhz),
        .rst  (rst),
        .tick (tick),
        .btn  (btn_next),
        .rise (next_rise_s)
    );

    btn_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_deb_prev (
        .clk  (sysclk_125mhz),
        .rst  (rst),
        .tick (tick),
        .btn  (btn_prev),
        .rise (prev_rise_s)
    );

    // Scroll FSM: a new digest overrides everything; a mode flip takes a whole
    // cycle of its own so no step is applied while switching.
    always_ff @(posedge sysclk_125mhz) begin
        if (rst) begin
            state_r    <= EMPTY;
            captured_r <= '0;
            index_r    <= '0;
            dwell_r    <= '0;
            loaded_r   <= 1'b0;
            wrap_r     <= 1'b0;
        end else begin
            wrap_r <= 1'b0;
            if (digest_valid) begin
                captured_r <= digest;
                index_r    <= IDX_LAST;
                dwell_r    <= '0;
                loaded_r   <= 1'b1;
                state_r    <= mode_auto ? AUTO : MANUAL;
            end else begin
                case (state_r)
                    EMPTY: begin
                        state_r <= EMPTY;
                    end
                    MANUAL: begin
                        if (mode_auto) begin
                            state_r <= AUTO;
                            dwell_r <= '0;
                        end else if (next_rise_s && !prev_rise_s) begin
                            index_r <= idx_step(index_r, 1'b0);
                        end else if (prev_rise_s && !next_rise_s) begin
                            index_r <= idx_step(index_r, 1'b1);
                        end else begin
                            index_r <= index_r;
                        end
                    end
                    AUTO: begin
                        if (!mode_auto) begin
                            state_r <= MANUAL;
                            dwell_r <= '0;
                        end else if (tick) begin
                            if (dwell_r == DWELL_LAST) begin
                                dwell_r <= '0;
                                index_r <= idx_step(index_r, 1'b0);
                                wrap_r  <= (index_r == 5'd0);
                            end else begin
                                dwell_r <= dwell_r + DWELL_ONE;
                            end
                        end else begin
                            dwell_r <= dwell_r;
                        end
                    end
                    default: begin
                        state_r <= EMPTY;
                        index_r <= '0;
                        dwell_r <= '0;
                    end
                endcase
            end
        end
    end

    // Word mux straight off the registers so word_out tracks index_out.
    always_comb begin
        word_s = '0;
        if (state_r == EMPTY) begin
            word_s = '0;
        end else begin
            word_s = captured_r[int'(index_r) * WORD_W +: WORD_W];
        end
    end

    assign word_out   = word_s;
    assign index_out  = index_r;
    assign loaded     = loaded_r;
    assign wrap_pulse = wrap_r;

endmodule
